// File: rtl/wb_result_stage.sv
// Writeback result stage: picks one of NUM_SRC result sources, registers it
// together with rd and the effective write enable behind a valid/ready
// output register, flags illegal selects and never writes x0.
// Optional load byte/half extraction: define WB_LOAD_EXT_EN.
module wb_result_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = $clog2(NUM_SRC),
    parameter int SRC_LOAD = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_SRC*XLEN-1:0] src_data,
    input  logic [SEL_W-1:0]        result_src,
    input  logic [4:0]              rd_addr,
    input  logic                    reg_write,
    input  logic [2:0]              ld_funct3,
    input  logic [1:0]              ld_addr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         wb_data,
    output logic [4:0]              wb_rd,
    output logic                    wb_we,
    output logic                    sel_err
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [XLEN-1:0]   src_arr [NUM_SRC];
    logic [XLEN-1:0]   sel_word;
    logic [XLEN-1:0]   result_next;
    logic              sel_legal;
    logic              accept;
    logic [XLEN-1:0]   wb_data_reg;
    logic [4:0]        wb_rd_reg;
    logic              wb_we_reg;
    logic              sel_err_reg;

    // Unpack the flat source bus into one word per source.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_arr[gi] = src_data[gi*XLEN +: XLEN];
        end
    endgenerate

    assign accept = in_valid && in_ready;

    // State register: FULL means the output register holds a live bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: fill on accept, drain when consumed with nothing new arriving.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY:   if (in_valid) state_next = FULL;
            FULL:    if (out_ready && !in_valid) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Handshake outputs; ready passes straight through so a stream never bubbles.
    always_comb begin
        out_valid = (state_reg == FULL);
        in_ready  = !out_valid || out_ready;
    end

    // Source mux; an out-of-range select matches nothing and yields zero.
    always_comb begin
        sel_legal = 32'(result_src) < 32'(NUM_SRC);
        sel_word  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (result_src == SEL_W'(i)) sel_word = src_arr[i];
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [XLEN-1:0] load_shift;

    // Align the addressed byte/half to bit 0, then size and extend it.
    always_comb begin
        load_shift  = sel_word >> {ld_addr_lo, 3'b000};
        result_next = sel_word;
        if (sel_legal && (32'(result_src) == 32'(SRC_LOAD))) begin
            case (ld_funct3)
                3'b000:  result_next = {{(XLEN-8){load_shift[7]}}, load_shift[7:0]};
                3'b001:  result_next = {{(XLEN-16){load_shift[15]}}, load_shift[15:0]};
                3'b100:  result_next = {{(XLEN-8){1'b0}}, load_shift[7:0]};
                3'b101:  result_next = {{(XLEN-16){1'b0}}, load_shift[15:0]};
                default: result_next = sel_word;
            endcase
        end
    end
`else
    logic unused_ld;
    assign unused_ld = ^{ld_funct3, ld_addr_lo};

    // Load data passes raw when extraction is not built in.
    always_comb begin
        result_next = sel_word;
    end
`endif

    // Output bundle register: loads on accept, otherwise holds (also when drained).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_reg <= '0;
            wb_rd_reg   <= '0;
            wb_we_reg   <= 1'b0;
        end else if (accept) begin
            wb_data_reg <= result_next;
            wb_rd_reg   <= rd_addr;
            wb_we_reg   <= reg_write && (rd_addr != 5'd0) && sel_legal;
        end
    end

    // Sticky illegal-select flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_reg <= 1'b0;
        end else if (accept && !sel_legal) begin
            sel_err_reg <= 1'b1;
        end
    end

    assign wb_data = wb_data_reg;
    assign wb_rd   = wb_rd_reg;
    assign wb_we   = wb_we_reg;
    assign sel_err = sel_err_reg;

endmodule

// File: doc/wb_result_stage.md
Name: wb_result_stage

Overview:
- Parametrised writeback result selector with a registered output stage, for the pipelined core.
- Selects one of NUM_SRC result sources (ALU result, load data, PC+4, immediate/CSR, ...) using a one-hot-free binary select.
- Captures the result with its destination register and write enable into one output register, which uses a valid/ready handshake for stalls.
- Adds illegal-select detection and x0 write suppression, plus optional load byte/half extraction.

Parameters:
- XLEN, 32, data width of every source and of the result.
- NUM_SRC, 4, number of result sources (2..8).
- SEL_W, $clog2(NUM_SRC), width of the select input; derived, not overridden.
- SRC_LOAD, 1, index of the source that carries raw memory read data.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream holds a valid result bundle.
- in_ready  output  1  stage can accept a bundle this cycle.
- src_data  input  NUM_SRC*XLEN  packed sources; source i occupies bits [i*XLEN +: XLEN].
- result_src  input  SEL_W  source select.
- rd_addr  input  5  destination register.
- reg_write  input  1  instruction writes rd.
- ld_funct3  input  3  load size/sign (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
- ld_addr_lo  input  2  byte offset of the load address.
- out_valid  output  1  output bundle valid.
- out_ready  input  1  register file/consumer accepts the bundle.
- wb_data  output  XLEN  registered result.
- wb_rd  output  5  registered destination.
- wb_we  output  1  registered effective write enable.
- sel_err  output  1  sticky flag: an illegal select was accepted.

Behaviour:
- Reset (async, rst_n low): out_valid=0, wb_data=0, wb_rd=0, wb_we=0, sel_err=0. These values hold while rst_n is low.
- Reset mid-transfer discards the held bundle. No output activity until 1 cycle after rst_n deasserts.
- in_ready = !out_valid || out_ready. This is combinational; there is no bubble on a continuous stream.
- Accept event: in_valid && in_ready at a rising clk. The bundle is registered with 1-cycle latency, and out_valid=1 the next cycle.
- When there is no accept but the held bundle is consumed (out_valid && out_ready): out_valid goes to 0. Data registers keep their value.
- Accept and consume in the same cycle: the new bundle replaces the old one and out_valid stays 1 (back-to-back throughput of 1 per cycle).
- When out_valid=1 and out_ready=0: all outputs are held stable and in_ready=0. Upstream must hold its inputs.
- Two implicit states:
  - EMPTY (out_valid=0): accept moves to FULL.
  - FULL: consume without accept moves to EMPTY; consume with accept stays FULL; stall stays FULL.
- Selection: result = src_data[result_src*XLEN +: XLEN] when result_src < NUM_SRC.
- Illegal select (result_src >= NUM_SRC, possible when NUM_SRC is not a power of 2): result=0 and wb_we=0. sel_err is set on accept and cleared only by reset.
- Effective write enable: wb_we = reg_write && (rd_addr != 0) && legal select. So x0 is never written, and wb_data is still registered in that case.
- The bundle is registered even when wb_we=0, so that out_valid tracks instruction retirement.

Optional Feature:
- Macro: WB_LOAD_EXT_EN.
- Defined: when result_src == SRC_LOAD, the word is shifted right by 8*ld_addr_lo before sizing.
  - lb/lh sign-extend bit 7/15 to XLEN.
  - lbu/lhu zero-extend.
  - lw passes the word unchanged.
  - Any other ld_funct3 passes the word unchanged.
  - A misaligned lh (ld_addr_lo=3) uses byte 3 with upper byte 0 before extension.
- Not defined: ld_funct3 and ld_addr_lo are ignored and the load source passes raw. Both ports remain present so the interface is identical.

Test Plan:
- Reset then stream: rst_n low 3 cycles → all outputs 0. Release, then src0=0x00000011, result_src=0, rd=5, reg_write=1 with out_ready=1 → next cycle out_valid=1, wb_data=0x11, wb_rd=5, wb_we=1.
- Back-to-back with stall: 3 bundles on consecutive cycles (src2=0x104/0x108/0x10C, result_src=2). out_ready=0 on cycle 2 → in_ready=0 and wb_data is held at 0x104 for the stall. After release, outputs are 0x104, 0x108, 0x10C in order with nothing lost or duplicated.
- x0 suppression: rd=0, reg_write=1, src0=0xDEADBEEF → out_valid=1, wb_data=0xDEADBEEF, wb_we=0.
- Illegal select with NUM_SRC=3: result_src=3 accepted → wb_data=0, wb_we=0, sel_err=1. sel_err is still 1 after 10 further legal bundles and 0 only after reset.
- WB_LOAD_EXT_EN load data: src1=0x80F0_7F81, result_src=1:
  - lb, off 0 → 0xFFFFFF81
  - lbu, off 3 → 0x00000080
  - lh, off 2 → 0xFFFF80F0
  - lw → 0x80F07F81
  - Without the macro, all four give 0x80F07F81.
- Async reset mid-stall: FULL with out_ready=0, rst_n pulsed low between clock edges → out_valid=0 immediately, without waiting for a clock edge; in_ready=1.
